// File: rtl/loop_ctrl.sv
// Round-robin arbiter sharing one loop engine among N requesters.
// Grants, issues a start pulse, waits for ack or timeout, then pulses done.
module loop_ctrl #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic         err,
  output logic         busy,
  output logic         eng_start,
  input  logic         eng_ack
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_id;
  logic [IW-1:0]   win;
  logic [CW-1:0]   cnt;
  logic            tmo_q;
  logic            err_q;
  logic            found;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      logic [IW-1:0] idx;
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      cnt       <= '0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_id    <= win;
            gnt       <= ONE << win;
            busy      <= 1'b1;
            eng_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start <= 1'b0;
          cnt       <= '0;
          tmo_q     <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // tmo_q registers the terminal count, so ack still wins one cycle after cnt saturates.
          if (eng_ack) begin
            err_q <= 1'b0;
            done  <= gnt;
            state <= RESP;
          end else if (tmo_q) begin
            err_q <= 1'b1;
            done  <= gnt;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done   <= '0;
          err_q  <= 1'b0;
          gnt    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// Randomized scoreboard bench for loop_ctrl with an arithmetic reference model
// of arbitration order and completion timing.
module tb_loop_ctrl;
  localparam int T = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt, done;
  logic       err, busy, eng_start, eng_ack;

  loop_ctrl #(.N(4), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .eng_start(eng_start), .eng_ack(eng_ack)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] d; logic e; int c;} exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  int rr_m = 0;
  int rc[4];
  logic [3:0] arb_req;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares every done pulse against the queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && cyc > sbq[0].c) begin
        checks++; errors++;
        $display("FAIL missed_done got=none exp=%b at cycle %0d", sbq[0].d, sbq[0].c);
        void'(sbq.pop_front());
      end
      if (done !== 4'b0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got=%b exp=none (cycle %0d)", done, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_vec", done, e.d);
          chk("done_err", err, e.e);
          chk("done_cycle", cyc, e.c);
        end
      end else if (err !== 1'b0) begin
        chk("err_without_done", err, 0);
      end
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("busy_vs_gnt", busy, |gnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int model_win(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (p + i) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic tick();
    arb_req = req;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (rc[i] > 0) begin
        rc[i]--;
        if (rc[i] == 0) req[i] = 1'b1;
      end
  endtask

  // k: cycle offset after start at which ack is high for one cycle (0 = during ISSUE, <0 = never)
  task automatic txn(input int k, input bit drop_wait, input int reassert,
                     output int winner, output int waited);
    logic [3:0] oh;
    logic       err_e;
    int         off;
    exp_t       e;
    waited = 0;
    winner = -1;
    do begin
      tick();
      waited++;
    end while (eng_start !== 1'b1 && waited < 40);
    if (eng_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL start_timeout got=no_start exp=start_pulse (cycle %0d)", cyc);
      return;
    end
    winner = model_win(arb_req, rr_m);
    oh = (winner < 0) ? 4'b0 : (4'b0001 << winner);
    chk("gnt_at_start", gnt, oh);
    chk("busy_at_start", busy, 1);
    if (winner < 0) return;
    err_e = !(k >= 1 && k <= T + 1);
    off   = err_e ? T + 2 : k + 1;
    e.d = oh; e.e = err_e; e.c = cyc + off;
    sbq.push_back(e);
    if (k == 0) eng_ack = 1'b1;
    for (int t = 1; t <= off; t++) begin
      tick();
      eng_ack = (t == k);
      if (t == 1) chk("start_one_cycle", eng_start, 0);
      if (drop_wait && t == 1) req[winner] = 1'b0;
    end
    eng_ack = 1'b0;
    req[winner] = 1'b0;
    if (reassert > 0) rc[winner] = reassert;
    rr_m = (winner + 1) % 4;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
  endtask

  task automatic quiesce(input int n);
    req = 4'b0;
    for (int i = 0; i < 4; i++) rc[i] = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int w, wt, k;
  int order[6];
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    for (int i = 0; i < 4; i++) rc[i] = 0;
    rst = 1'b1; req = 4'b1111; eng_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mon_en = 1;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_busy", busy, 0);
    end
    rst = 1'b0;

    // Round-robin with all requesters, each dropping after done and reasserting 5 cycles later
    for (int n = 0; n < 6; n++) begin
      txn($urandom_range(1, 15), 0, 5, w, wt);
      order[n] = w;
      chk("rr_order", w, exp_order[n]);
      chk("rr_back_to_back", wt, 1);
    end
    quiesce(3);

    // Single requester, ack 15 cycles after start
    req = 4'b0100;
    txn(15, 0, 0, w, wt);
    chk("single_winner", w, 2);
    quiesce(2);

    // Timeout, then next arbitration starts at requester 1
    req = 4'b0001;
    txn(-1, 0, 0, w, wt);
    req = 4'b1111;
    txn(3, 0, 0, w, wt);
    chk("after_timeout_winner", w, 1);
    quiesce(2);

    // Ack on the last WAIT cycle wins; ack one cycle later is too late; ack in ISSUE ignored
    req = 4'b0010; txn(T + 1, 0, 0, w, wt); quiesce(1);
    req = 4'b0010; txn(T, 0, 0, w, wt);     quiesce(1);
    req = 4'b0010; txn(T + 2, 0, 0, w, wt); quiesce(1);
    req = 4'b1000; txn(0, 0, 0, w, wt);     quiesce(1);

    // Requester drops in WAIT
    req = 4'b0100; txn(6, 1, 0, w, wt); quiesce(1);

    // Randomized traffic
    for (int n = 0; n < 12; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) k = -1;
      else if (r == 1) k = 0;
      else if (r == 2) k = T + $urandom_range(0, 2);
      else k = $urandom_range(1, 15);
      for (int i = 0; i < 4; i++) rc[i] = 0;
      req = 4'($urandom_range(1, 15));
      txn(k, 1'($urandom_range(0, 1)), 0, w, wt);
    end
    quiesce(2);

    // Reset during WAIT: leave rr_ptr at 3 first so a stale pointer would be visible
    req = 4'b0100; txn(4, 0, 0, w, wt); quiesce(1);
    req = 4'b0010;
    wt = 0;
    do begin tick(); wt++; end while (eng_start !== 1'b1 && wt < 40);
    chk("midrst_started", eng_start, 1);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_start", eng_start, 0);
    rst = 1'b0;
    rr_m = 0;
    req = 4'b0;
    for (int i = 0; i < 4; i++) rc[i] = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_reissue", eng_start, 0);
    end
    req = 4'b1001; txn(5, 0, 0, w, wt);
    chk("midrst_rr_reset", w, 0);
    quiesce(1);
    req = 4'b1000; txn(9, 0, 0, w, wt);
    chk("midrst_served", w, 3);
    quiesce(5);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
